// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
// Holds the FSM state encoding, reset/increment defaults and the wrapping PC adder.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        MISS = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
    localparam logic [15:0] PC_INC_DEFAULT   = 16'd2;

    // 16-bit add that wraps modulo 2^16
    function automatic logic [15:0] pc_add(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/pc_pending_redirect.sv
// Holds a branch redirect that arrived while an instruction miss was outstanding.
// clear wins over capture, so a redirect consumed on the fill edge never lingers.
module pc_pending_redirect
    import pc_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        clear,
    input  logic [15:0] capture_target,
    output logic        valid,
    output logic [15:0] target
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= 1'b0;
            target <= 16'h0000;
        end else if (clear) begin
            valid  <= 1'b0;
        end else if (capture) begin
            valid  <= 1'b1;
            target <= capture_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential fetch, branch redirect, miss wait and halt.
// All control outputs decode from registered state plus current inputs.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [15:0] PC_INC   = PC_INC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_miss,
    input  logic        imem_fill_done,
    input  logic        hazard_stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        halt_dec,
    output logic [15:0] pc,
    output logic [15:0] pc_plus_inc,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        halted
);

    state_t      state;
    state_t      next_state;
    logic [15:0] next_pc;
    logic        pend_capture;
    logic        pend_clear;
    logic        pend_valid;
    logic [15:0] pend_target;

    assign pc_plus_inc = pc_add(pc, PC_INC);
    assign halted      = (state == HALT);

    pc_pending_redirect u_pending (
        .clk            (clk),
        .rst            (rst),
        .capture        (pend_capture),
        .clear          (pend_clear),
        .capture_target (branch_target),
        .valid          (pend_valid),
        .target         (pend_target)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= next_state;
            if (pc_we) begin
                pc <= next_pc;
            end
        end
    end

    always_comb begin
        next_state   = state;
        next_pc      = pc_plus_inc;
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        pend_capture = 1'b0;
        pend_clear   = 1'b0;
        if (!rst) begin
            ifid_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hazard_stall) begin
                        // hold everything; branch/halt are re-presented by decode
                    end else if (branch_taken) begin
                        // a miss on the wrong-path fetch is simply abandoned
                        next_pc    = branch_target;
                        pc_we      = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (halt_dec) begin
                        next_state = HALT;
                    end else if (imem_miss) begin
                        ifid_flush = 1'b1;
                        next_state = MISS;
                    end else begin
                        pc_we   = 1'b1;
                        ifid_we = 1'b1;
                    end
                end
                MISS: begin
                    if (imem_fill_done) begin
                        next_state = RUN;
                        pend_clear = 1'b1;
                        pc_we      = 1'b1;
                        // a branch in the fill cycle is newer than any pending one
                        if (branch_taken) begin
                            next_pc    = branch_target;
                            ifid_flush = 1'b1;
                        end else if (pend_valid) begin
                            next_pc    = pend_target;
                            ifid_flush = 1'b1;
                        end else begin
                            ifid_we = 1'b1;
                        end
                    end else begin
                        ifid_flush   = 1'b1;
                        pend_capture = branch_taken;
                    end
                end
                HALT: begin
                end
                default: begin
                    next_state = RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a scoreboard of expected per-cycle results.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        imem_miss;
    logic        imem_fill_done;
    logic        hazard_stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt_dec;
    logic [15:0] pc;
    logic [15:0] pc_plus_inc;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        we;
        logic        ifid;
        logic        flush;
        logic        hlt;
        logic [15:0] pc_next;
    } exp_t;

    exp_t sb[$];

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_miss      (imem_miss),
        .imem_fill_done (imem_fill_done),
        .hazard_stall   (hazard_stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .halt_dec       (halt_dec),
        .pc             (pc),
        .pc_plus_inc    (pc_plus_inc),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs for the coming cycle plus what the DUT must do in it
    task automatic step(input string tag, input logic hs, input logic br, input logic [15:0] bt,
                        input logic hd, input logic ms, input logic fd,
                        input logic we, input logic ifid, input logic fl, input logic hl,
                        input logic [15:0] pcn);
        exp_t e;
        hazard_stall   = hs;
        branch_taken   = br;
        branch_target  = bt;
        halt_dec       = hd;
        imem_miss      = ms;
        imem_fill_done = fd;
        e.tag = tag; e.we = we; e.ifid = ifid; e.flush = fl; e.hlt = hl; e.pc_next = pcn;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_pc_we"}, {15'd0, pc_we}, {15'd0, e.we});
            chk({e.tag, "_ifid_we"}, {15'd0, ifid_we}, {15'd0, e.ifid});
            chk({e.tag, "_flush"}, {15'd0, ifid_flush}, {15'd0, e.flush});
            chk({e.tag, "_halted"}, {15'd0, halted}, {15'd0, e.hlt});
            chk({e.tag, "_pc_plus_inc"}, pc_plus_inc, pc + 16'd2);
            @(posedge clk);
            #1;
            chk({e.tag, "_pc"}, pc, e.pc_next);
        end
    endtask

    task automatic idle(input string tag, input logic [15:0] pcn);
        step(tag, 0, 0, 16'h0, 0, 0, 0, 1, 1, 0, 0, pcn);
    endtask

    task automatic do_reset(input string tag);
        hazard_stall = 0; branch_taken = 0; branch_target = 16'h0;
        halt_dec = 0; imem_miss = 0; imem_fill_done = 0;
        rst = 1'b0;
        #1;
        chk({tag, "_rst_pc"}, pc, 16'h0000);
        chk({tag, "_rst_pc_we"}, {15'd0, pc_we}, 16'd0);
        chk({tag, "_rst_ifid_we"}, {15'd0, ifid_we}, 16'd0);
        chk({tag, "_rst_flush"}, {15'd0, ifid_flush}, 16'd1);
        chk({tag, "_rst_halted"}, {15'd0, halted}, 16'd0);
        @(posedge clk);
        #1;
        chk({tag, "_rst_pc_held"}, pc, 16'h0000);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        hazard_stall = 0; branch_taken = 0; branch_target = 16'h0;
        halt_dec = 0; imem_miss = 0; imem_fill_done = 0;
        @(posedge clk);
        #1;
        do_reset("init");

        // sequential fetch after reset
        for (int i = 1; i <= 8; i++) idle("seq", 16'(2 * i));

        // stall beats a branch; nothing moves
        step("stall1", 1, 1, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 16'h0010);
        step("stall2", 1, 1, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 16'h0010);
        idle("after_stall", 16'h0012);
        for (int i = 0; i < 7; i++) idle("to20", 16'(16'h0014 + 2 * i));

        // miss, branch captured in MISS, fill redirects
        step("miss_enter", 0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0020);
        step("miss_c1",    0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0020);
        step("miss_c2_br", 0, 1, 16'h0200, 0, 1, 0, 0, 0, 1, 0, 16'h0020);
        step("miss_c3",    0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0020);
        step("miss_fill",  0, 0, 16'h0, 0, 0, 1, 1, 0, 1, 0, 16'h0200);
        idle("post_fill_run", 16'h0202);

        // wrap, then branch overriding a same-cycle miss
        step("br_fffe", 0, 1, 16'hFFFE, 0, 0, 0, 1, 0, 1, 0, 16'hFFFE);
        idle("wrap", 16'h0000);
        step("br_miss", 0, 1, 16'h0040, 0, 1, 0, 1, 0, 1, 0, 16'h0040);
        idle("br_miss_run", 16'h0042);

        // fill-cycle branch beats pending; plain fill; pending is cleared after use
        step("m2_enter",  0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0042);
        step("m2_br",     0, 1, 16'h0300, 0, 0, 0, 0, 0, 1, 0, 16'h0042);
        step("m2_br_ovr", 0, 1, 16'h0350, 0, 0, 0, 0, 0, 1, 0, 16'h0042);
        step("m2_fillbr", 0, 1, 16'h0400, 0, 0, 1, 1, 0, 1, 0, 16'h0400);
        step("m3_enter",  0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0400);
        step("m3_fill",   0, 0, 16'h0, 0, 0, 1, 1, 1, 0, 0, 16'h0402);
        step("m4_enter",  0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0402);
        step("m4_br",     0, 1, 16'h0500, 0, 0, 0, 0, 0, 1, 0, 16'h0402);
        step("m4_fill",   0, 0, 16'h0, 0, 0, 1, 1, 0, 1, 0, 16'h0500);
        step("m5_enter",  0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0500);
        step("m5_fill",   0, 0, 16'h0, 0, 0, 1, 1, 1, 0, 0, 16'h0502);

        // halt ignores everything until reset
        step("br_30", 0, 1, 16'h0030, 0, 0, 0, 1, 0, 1, 0, 16'h0030);
        step("halt_dec", 0, 0, 16'h0, 1, 0, 0, 0, 0, 0, 0, 16'h0030);
        for (int i = 0; i < 10; i++)
            step("halted", 0, 1, 16'h0600, 0, 1, 1, 0, 0, 0, 1, 16'h0030);
        do_reset("halt_rst");
        idle("halt_rst_seq", 16'h0002);

        // reset mid-MISS discards the pending redirect
        step("m6_enter", 0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0002);
        step("m6_br",    0, 1, 16'h0700, 0, 0, 0, 0, 0, 1, 0, 16'h0002);
        do_reset("miss_rst");
        idle("miss_rst_seq", 16'h0002);
        step("m7_enter", 0, 0, 16'h0, 0, 1, 0, 0, 0, 1, 0, 16'h0002);
        step("m7_fill",  0, 0, 16'h0, 0, 0, 1, 1, 1, 0, 0, 16'h0004);

        chk("sb_drained", 16'(sb.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
